// File: rtl/sweep_controller.sv
// sweep_controller: runs a multi-sweep frequency scan by gating the point sequencer's
// active-low reset, counting completed points from falling edges of the accumulator
// trigger, and supervising progress with a stall watchdog.
//
// Ports:
//   aclk, rst            clock; asynchronous active-low reset
//   start, abort         single-cycle control requests (abort wins over start)
//   num_points           points per sweep (0 = immediate empty sweep)
//   num_sweeps           sweeps per run (0 = continuous until abort)
//   timeout              watchdog limit in RUN cycles (0 = disabled)
//   accumulator_trigger  sequencer trigger; falling edge = point finished
//   seq_rst              active-low reset to the sequencer
//   point_index          points completed in the current sweep
//   sweep_index          sweeps completed in the current run
//   point_done           one-cycle pulse per completed point
//   sweep_done           one-cycle pulse per completed sweep
//   busy                 run in progress
//   error                sticky watchdog flag, cleared by the next accepted start
module sweep_controller #(
   parameter int unsigned ARM_CYCLES = 4,
   parameter int unsigned SWEEP_W    = 16
) (
   input  logic               aclk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        num_points,
   input  logic [SWEEP_W-1:0] num_sweeps,
   input  logic [31:0]        timeout,
   input  logic               accumulator_trigger,
   output logic               seq_rst,
   output logic [31:0]        point_index,
   output logic [SWEEP_W-1:0] sweep_index,
   output logic               point_done,
   output logic               sweep_done,
   output logic               busy,
   output logic               error
);

   typedef enum logic [2:0] {StIdle, StArm, StRun, StGap, StErr} state_e;

   localparam logic [7:0] ArmLast = 8'(ARM_CYCLES - 1);

   state_e             state_q, state_d;
   logic               seq_rst_q, seq_rst_d;
   logic [31:0]        point_index_q, point_index_d;
   logic [SWEEP_W-1:0] sweep_index_q, sweep_index_d;
   logic               point_done_q, point_done_d;
   logic               sweep_done_q, sweep_done_d;
   logic               busy_q, busy_d;
   logic               error_q, error_d;
   logic               acc_q, acc_d;
   logic [7:0]         arm_cnt_q, arm_cnt_d;
   logic [31:0]        wdog_cnt_q, wdog_cnt_d;
   logic [31:0]        num_points_q, num_points_d;
   logic [SWEEP_W-1:0] num_sweeps_q, num_sweeps_d;
   logic [31:0]        timeout_q, timeout_d;

   logic               fall;
   logic [SWEEP_W-1:0] sweep_next;

   assign fall       = (state_q == StRun) & acc_q & ~accumulator_trigger;
   assign sweep_next = sweep_index_q + SWEEP_W'(1);

   always_comb begin
      state_d       = state_q;
      seq_rst_d     = seq_rst_q;
      point_index_d = point_index_q;
      sweep_index_d = sweep_index_q;
      point_done_d  = 1'b0;
      sweep_done_d  = 1'b0;
      busy_d        = busy_q;
      error_d       = error_q;
      acc_d         = 1'b0;   // edge history only survives inside RUN
      arm_cnt_d     = arm_cnt_q;
      wdog_cnt_d    = wdog_cnt_q;
      num_points_d  = num_points_q;
      num_sweeps_d  = num_sweeps_q;
      timeout_d     = timeout_q;

      if (abort) begin
         // Counters and error are kept for readback; no completion pulses.
         state_d   = StIdle;
         seq_rst_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StErr: begin
               seq_rst_d = 1'b0;
               if (start) begin
                  num_points_d  = num_points;
                  num_sweeps_d  = num_sweeps;
                  timeout_d     = timeout;
                  point_index_d = '0;
                  sweep_index_d = '0;
                  error_d       = 1'b0;
                  arm_cnt_d     = '0;
                  wdog_cnt_d    = '0;
                  if (num_points == '0) begin
                     // Empty sweep: report completion without touching the sequencer.
                     sweep_done_d = 1'b1;
                     busy_d       = 1'b0;
                     state_d      = StIdle;
                  end else begin
                     busy_d  = 1'b1;
                     state_d = StArm;
                  end
               end
            end
            StArm, StGap: begin
               seq_rst_d     = 1'b0;
               point_index_d = '0;
               wdog_cnt_d    = '0;
               if (arm_cnt_q == ArmLast) begin
                  arm_cnt_d = '0;
                  seq_rst_d = 1'b1;
                  state_d   = StRun;
               end else begin
                  arm_cnt_d = arm_cnt_q + 8'd1;
               end
            end
            StRun: begin
               acc_d = accumulator_trigger;
               // A fall takes precedence over a watchdog expiry in the same cycle.
               if (fall) begin
                  point_done_d  = 1'b1;
                  point_index_d = point_index_q + 32'd1;
                  wdog_cnt_d    = '0;
                  if (point_index_q == num_points_q - 32'd1) begin
                     sweep_done_d  = 1'b1;
                     sweep_index_d = sweep_next;
                     seq_rst_d     = 1'b0;
                     arm_cnt_d     = '0;
                     if ((num_sweeps_q != '0) && (sweep_next == num_sweeps_q)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                     end else begin
                        state_d = StGap;
                     end
                  end
               end else if ((timeout_q != '0) && (wdog_cnt_q == timeout_q - 32'd1)) begin
                  state_d   = StErr;
                  seq_rst_d = 1'b0;
                  error_d   = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  wdog_cnt_d = wdog_cnt_q + 32'd1;
               end
            end
            default: begin
               state_d   = StIdle;
               seq_rst_d = 1'b0;
               busy_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         seq_rst_q     <= 1'b0;
         point_index_q <= '0;
         sweep_index_q <= '0;
         point_done_q  <= 1'b0;
         sweep_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         error_q       <= 1'b0;
         acc_q         <= 1'b0;
         arm_cnt_q     <= '0;
         wdog_cnt_q    <= '0;
         num_points_q  <= '0;
         num_sweeps_q  <= '0;
         timeout_q     <= '0;
      end else begin
         state_q       <= state_d;
         seq_rst_q     <= seq_rst_d;
         point_index_q <= point_index_d;
         sweep_index_q <= sweep_index_d;
         point_done_q  <= point_done_d;
         sweep_done_q  <= sweep_done_d;
         busy_q        <= busy_d;
         error_q       <= error_d;
         acc_q         <= acc_d;
         arm_cnt_q     <= arm_cnt_d;
         wdog_cnt_q    <= wdog_cnt_d;
         num_points_q  <= num_points_d;
         num_sweeps_q  <= num_sweeps_d;
         timeout_q     <= timeout_d;
      end
   end

   assign seq_rst     = seq_rst_q;
   assign point_index = point_index_q;
   assign sweep_index = sweep_index_q;
   assign point_done  = point_done_q;
   assign sweep_done  = sweep_done_q;
   assign busy        = busy_q;
   assign error       = error_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Testbench for sweep_controller: directed scenarios followed by a randomized phase,
// with a simple sequencer model driving accumulator_trigger and a cycle-level
// reference model of the controller's observable behaviour.
module tb_sweep_controller;

   localparam int ARM = 4;

   logic        aclk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] np_in;
   logic [15:0] ns_in;
   logic [31:0] to_in;
   logic        trig;
   logic        seq_rst;
   logic [31:0] point_index;
   logic [15:0] sweep_index;
   logic        point_done;
   logic        sweep_done;
   logic        busy;
   logic        error;

   sweep_controller #(
      .ARM_CYCLES (ARM),
      .SWEEP_W    (16)
   ) dut (
      .aclk                (aclk),
      .rst                 (rst),
      .start               (start),
      .abort               (abort),
      .num_points          (np_in),
      .num_sweeps          (ns_in),
      .timeout             (to_in),
      .accumulator_trigger (trig),
      .seq_rst             (seq_rst),
      .point_index         (point_index),
      .sweep_index         (sweep_index),
      .point_done          (point_done),
      .sweep_done          (sweep_done),
      .busy                (busy),
      .error               (error)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: latched config plus run progress.
   logic [31:0] c_np, c_to;
   logic [15:0] c_ns;
   bit          m_active;    // a run is in progress (arming or running)
   int          m_arm_left;  // remaining sequencer-reset cycles before running
   bit          m_prev;      // trigger level seen on the previous running cycle
   int          m_quiet;     // running cycles since run entry or last point
   logic [31:0] m_pi;
   logic [15:0] m_si;
   bit          m_pd, m_sd, m_busy, m_err, m_seqrst;

   // Sequencer model: low for dead_t cycles, high for point_t cycles, repeat.
   int sq_cnt, dead_t, point_t;
   bit hold_low;

   int pd_seen, sd_seen, hi_seen;

   task automatic model_reset();
      c_np = '0; c_to = '0; c_ns = '0;
      m_active = 0; m_arm_left = 0; m_prev = 0; m_quiet = 0;
      m_pi = '0; m_si = '0;
      m_pd = 0; m_sd = 0; m_busy = 0; m_err = 0; m_seqrst = 0;
   endtask

   task automatic model_step();
      bit running, fall;
      running = m_active && (m_arm_left == 0);
      fall    = running && m_prev && !trig;
      m_pd = 0;
      m_sd = 0;
      if (abort) begin
         m_active = 0; m_arm_left = 0; m_seqrst = 0; m_busy = 0;
      end else if (!m_active) begin
         m_seqrst = 0;
         if (start) begin
            c_np = np_in; c_ns = ns_in; c_to = to_in;
            m_pi = '0; m_si = '0; m_err = 0; m_quiet = 0;
            if (np_in == 32'd0) m_sd = 1;
            else begin
               m_active = 1; m_arm_left = ARM; m_busy = 1;
            end
         end
      end else if (m_arm_left > 0) begin
         m_pi = '0;
         m_arm_left--;
         if (m_arm_left == 0) begin
            m_seqrst = 1; m_quiet = 0;
         end
      end else if (fall) begin
         m_pd = 1; m_pi = m_pi + 32'd1; m_quiet = 0;
         if (m_pi == c_np) begin
            m_sd = 1; m_si = m_si + 16'd1; m_seqrst = 0;
            if (c_ns != 16'd0 && m_si == c_ns) begin
               m_active = 0; m_busy = 0;
            end else m_arm_left = ARM;
         end
      end else begin
         m_quiet++;
         if (c_to != 32'd0 && 32'(m_quiet) == c_to) begin
            m_active = 0; m_busy = 0; m_err = 1; m_seqrst = 0;
         end
      end
      m_prev = running && trig;
   endtask

   task automatic seq_step();
      if (!m_seqrst || hold_low) begin
         sq_cnt = 0; trig = 1'b0;
      end else begin
         trig = ((sq_cnt % (dead_t + point_t)) >= dead_t);
         sq_cnt++;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("seq_rst",     32'(seq_rst),     32'(m_seqrst));
      check("point_index", point_index,      m_pi);
      check("sweep_index", 32'(sweep_index), 32'(m_si));
      check("point_done",  32'(point_done),  32'(m_pd));
      check("sweep_done",  32'(sweep_done),  32'(m_sd));
      check("busy",        32'(busy),        32'(m_busy));
      check("error",       32'(error),       32'(m_err));
   endtask

   task automatic tick();
      model_step();
      @(posedge aclk);
      #1;
      compare_all();
      if (point_done === 1'b1) pd_seen++;
      if (sweep_done === 1'b1) sd_seen++;
      if (seq_rst === 1'b1) hi_seen++;
      seq_step();
   endtask

   task automatic run_until_idle(input string tag, input int bound);
      int n;
      n = 0;
      while (m_active && n < bound) begin
         tick();
         n++;
      end
      n_assert++;
      assert (!m_active) else begin
         n_fail++;
         $error("FAIL %s: run still active after %0d cycles, expected idle", tag, n);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0; start = 1'b0; abort = 1'b0; trig = 1'b0;
      np_in = '0; ns_in = '0; to_in = '0;
      dead_t = 5; point_t = 20; hold_low = 0; sq_cnt = 0;
      pd_seen = 0; sd_seen = 0; hi_seen = 0;
      model_reset();

      // Reset values
      repeat (3) @(posedge aclk);
      #1;
      compare_all();
      rst = 1'b1;
      repeat (2) tick();

      // Single sweep of three points
      np_in = 32'd3; ns_in = 16'd1; to_in = 32'd0;
      pd_seen = 0; sd_seen = 0;
      pulse_start();
      n = 0;
      while (seq_rst === 1'b0 && n < 20) begin
         n++;
         tick();
      end
      check("arm_low_cycles", 32'(n), 32'd4);
      run_until_idle("sweep1", 200);
      check("sweep1_points", 32'(pd_seen), 32'd3);
      check("sweep1_sweeps", 32'(sd_seen), 32'd1);
      check("sweep1_point_index", point_index, 32'd3);
      check("sweep1_sweep_index", 32'(sweep_index), 32'd1);
      check("sweep1_busy", 32'(busy), 32'd0);

      // Three sweeps of two points
      np_in = 32'd2; ns_in = 16'd3;
      sd_seen = 0;
      pulse_start();
      run_until_idle("sweep3", 400);
      check("sweep3_sweeps", 32'(sd_seen), 32'd3);
      check("sweep3_sweep_index", 32'(sweep_index), 32'd3);

      // Continuous mode, abort after five sweeps
      np_in = 32'd1; ns_in = 16'd0;
      pulse_start();
      n = 0;
      while (!(m_si == 16'd5 && m_active && m_arm_left == 0) && n < 1000) begin
         n++;
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("cont_sweep_index", 32'(sweep_index), 32'd5);
      check("cont_busy", 32'(busy), 32'd0);
      check("cont_seq_rst", 32'(seq_rst), 32'd0);

      // Watchdog expiry with trigger held low, then restart from the error state
      np_in = 32'd2; ns_in = 16'd1; to_in = 32'd50; hold_low = 1;
      pulse_start();
      run_until_idle("wdog", 200);
      check("wdog_error", 32'(error), 32'd1);
      check("wdog_seq_rst", 32'(seq_rst), 32'd0);
      hold_low = 0;
      np_in = 32'd1; to_in = 32'd0;
      pulse_start();
      check("restart_error", 32'(error), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      run_until_idle("restart", 200);

      // Abort coinciding with the final fall
      np_in = 32'd2; ns_in = 16'd1;
      pulse_start();
      n = 0;
      while (!(m_active && m_arm_left == 0 && m_prev && !trig && m_pi == c_np - 32'd1)
             && n < 300) begin
         n++;
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_fall_pd", 32'(point_done), 32'd0);
      check("abort_fall_sd", 32'(sweep_done), 32'd0);
      check("abort_fall_sweep_index", 32'(sweep_index), 32'd0);

      // Start while busy is ignored, including its config
      np_in = 32'd3;
      pulse_start();
      repeat (6) tick();
      np_in = 32'd7;
      pulse_start();
      run_until_idle("busy_start", 300);
      check("busy_start_point_index", point_index, 32'd3);

      // Start together with abort in idle
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 32'd0);

      // Empty sweep
      np_in = 32'd0;
      sd_seen = 0; hi_seen = 0;
      pulse_start();
      repeat (6) tick();
      check("empty_sweeps", 32'(sd_seen), 32'd1);
      check("empty_seq_rst_high", 32'(hi_seen), 32'd0);

      // Asynchronous reset in the middle of a running sweep
      np_in = 32'd2;
      pulse_start();
      n = 0;
      while (!(m_active && m_arm_left == 0 && m_quiet >= 3) && n < 100) begin
         n++;
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      seq_step();
      #2;
      rst = 1'b1;
      repeat (2) tick();

      // Randomized phase: config changes every cycle, latched only on accepted starts
      for (int i = 0; i < 2500; i++) begin
         np_in = $urandom_range(0, 4);
         ns_in = 16'($urandom_range(0, 3));
         to_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(15, 60)) : 32'd0;
         start = ($urandom_range(0, 19) == 0);
         abort = ($urandom_range(0, 249) == 0);
         if (start && !m_active) begin
            dead_t   = $urandom_range(1, 6);
            point_t  = $urandom_range(2, 20);
            hold_low = ($urandom_range(0, 7) == 0);
         end
         tick();
      end
      start = 1'b0; abort = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
- Runs a frequency sweep of `num_points` points, repeated `num_sweeps` times, by gating the point sequencer's active-low reset.
- Counts completed points from the falling edges of the sequencer's accumulator trigger.
- Between sweeps it briefly re-asserts the sequencer reset, so the sequencer re-latches its config and re-arms its first-point trigger behaviour.
- Sits between the AXI-lite control registers and the point sequencer; provides progress counters, completion pulses and a stall watchdog.

Parameters:
- ARM_CYCLES, 4: cycles `seq_rst` is held low before each sweep. Legal range 2..255.
- SWEEP_W, 16: width of `num_sweeps` and `sweep_index`.

Ports:
- aclk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start request.
- abort  in  1  single-cycle abort request.
- num_points  in  32  points per sweep; latched on accepted start.
- num_sweeps  in  SWEEP_W  sweeps per run; 0 = continuous until abort; latched on accepted start.
- timeout  in  32  watchdog limit in cycles; 0 = watchdog disabled; latched on accepted start.
- accumulator_trigger  in  1  from the sequencer; its falling edge marks end of a point.
- seq_rst  out  1  active-low reset to the sequencer; 0 = sequencer held in reset.
- point_index  out  32  points completed in the current sweep.
- sweep_index  out  SWEEP_W  sweeps completed in the current run.
- point_done  out  1  one-cycle pulse per completed point.
- sweep_done  out  1  one-cycle pulse per completed sweep.
- busy  out  1  high while a run is in progress.
- error  out  1  sticky watchdog flag; cleared on the next accepted start.

Behaviour:
- Reset values (async, all registers): state = IDLE; `seq_rst` = 0; `point_index` = 0; `sweep_index` = 0; `point_done` = 0; `sweep_done` = 0; `busy` = 0; `error` = 0; `acc_d` = 0; arm counter and watchdog counter = 0.
- All outputs are registered.
- States: IDLE, ARM, RUN, GAP, ERR.
- IDLE:
  - `seq_rst` = 0.
  - An accepted start latches config, clears `point_index`, `sweep_index` and `error`, sets `busy`, and goes to ARM.
  - If `num_points` = 0: no ARM. Next cycle `sweep_done` pulses once, `busy` = 0, stay IDLE.
- ARM and GAP:
  - `seq_rst` = 0 for exactly ARM_CYCLES cycles.
  - `acc_d` is cleared.
  - Then go to RUN with `seq_rst` = 1 on the first RUN cycle.
- RUN:
  - Fall detect: `acc_d` & ~`accumulator_trigger`, where `acc_d` is `accumulator_trigger` registered.
  - On a fall:
    - Next cycle `point_done` = 1 and `point_index` increments.
    - Watchdog counter clears.
  - On the fall where `point_index` = `num_points` − 1:
    - Next cycle `point_done` = 1, `sweep_done` = 1, `point_index` = `num_points`, `seq_rst` = 0, `sweep_index` increments.
    - If `sweep_index` + 1 = `num_sweeps` (`num_sweeps` ≠ 0): go to IDLE, `busy` = 0 on that same cycle.
    - Otherwise go to GAP and `point_index` clears to 0 on the first GAP cycle.
  - `sweep_index` wraps at 2^SWEEP_W in continuous mode; no error is raised.
- Watchdog (RUN only, `timeout` ≠ 0):
  - The counter counts RUN cycles since entry or since the last fall.
  - When it reaches `timeout`: go to ERR; `seq_rst` = 0, `error` = 1, `busy` = 0.
  - A fall in the same cycle as timeout is honoured and the watchdog is not triggered.
- ERR:
  - Holds `seq_rst` = 0 and keeps `point_index` and `sweep_index` for readback.
  - An accepted start behaves as in IDLE.
- Start acceptance:
  - Accepted only in IDLE or ERR; ignored when `busy` = 1.
  - Start together with abort: abort wins and the start is not accepted.
- Abort, from any state:
  - Next cycle: IDLE, `seq_rst` = 0, `busy` = 0.
  - No `point_done` or `sweep_done`, even if a fall coincides.
  - Counters hold their values.
  - `error` is unchanged.
- Reset asserted mid-run: immediate return to reset values; `seq_rst` drops asynchronously.

Test Plan:
- ARM_CYCLES = 4, `num_points` = 3, `num_sweeps` = 1, sequencer modelled with point_time = 20, dead_time = 5; pulse start -> `seq_rst` low for 4 cycles then high; three `point_done` pulses, each 1 cycle after the fall; `sweep_done` with the third; `busy` falls the same cycle; final `point_index` = 3, `sweep_index` = 1.
- `num_points` = 2, `num_sweeps` = 3 -> `seq_rst` low for exactly 4 cycles between sweeps; `point_index` sequence 1, 2, 0, …; 3 `sweep_done` pulses; `busy` = 0 after the third.
- `num_sweeps` = 0, `num_points` = 1, abort after 5 sweeps -> `sweep_index` = 5, no pulse on the abort cycle, `seq_rst` = 0 and `busy` = 0 the next cycle.
- `timeout` = 50, `accumulator_trigger` held low in RUN -> ERR at RUN cycle 50; `error` = 1, `seq_rst` = 0; start pulse sent while in ERR is accepted and clears `error`.
- Abort in the same cycle as the fall of the last point -> no `point_done` or `sweep_done`, `sweep_index` unchanged; start while busy is ignored; start+abort in IDLE leaves `busy` = 0.
- `num_points` = 0 -> `seq_rst` never high; single `sweep_done` pulse; async reset asserted mid-RUN drives all outputs to reset values without a clock edge.
